// File: rtl/state_dump_pkg.sv
// Shared types and constants for the state_dump debug readout engine.
package state_dump_pkg;

  localparam int RF_AW = 5;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    RD,
    WAIT,
    SEND,
    DONE
  } dump_state_t;

  typedef enum logic {
    PH_RF,
    PH_MEM
  } phase_t;

endpackage

// File: rtl/state_dump.sv
// Debug readout engine: halts the core, then streams every register-file
// entry followed by the first MEM_WORDS data-memory words as tagged beats.
//
// state | meaning
// IDLE  | waiting for start
// HALT  | halt_req asserted, waiting for halt_ack
// RD    | read address driven; register data captured here
// WAIT  | memory phase only, synchronous memory data captured here
// SEND  | beat presented on out_valid until out_ready
// DONE  | one-cycle completion pulse
module state_dump
  import state_dump_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  output logic             halt_req,
  input  logic             halt_ack,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             mem_ren,
  output logic [IDX_W-1:0] mem_raddr,
  input  logic [31:0]      mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_mem,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] RF_LAST  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

  dump_state_t      state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_beat;

  assign last_beat = (phase_q == PH_RF) ? (idx_q == RF_LAST) : (idx_q == MEM_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      phase_q <= PH_RF;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HALT;
          phase_d = PH_RF;
          idx_d   = '0;
        end
      end
      HALT: begin
        if (halt_ack) state_d = RD;
      end
      RD: begin
        state_d = (phase_q == PH_MEM) ? WAIT : SEND;
      end
      WAIT: begin
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (!last_beat) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD;
          end else if (phase_q == PH_RF) begin
            phase_d = PH_MEM;
            idx_d   = '0;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat register is only loaded on the way into SEND, so it holds through any stall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_is_mem <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
    end else if (state_q == RD && phase_q == PH_RF) begin
      out_is_mem <= 1'b0;
      out_idx    <= idx_q;
      out_data   <= rf_rdata;
    end else if (state_q == WAIT) begin
      out_is_mem <= 1'b1;
      out_idx    <= idx_q;
      out_data   <= mem_rdata;
    end
  end

  assign halt_req  = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == SEND);
  assign mem_ren   = (state_q == RD) && (phase_q == PH_MEM);
  assign rf_raddr  = (phase_q == PH_RF)  ? idx_q[RF_AW-1:0] : '0;
  assign mem_raddr = (phase_q == PH_MEM) ? idx_q : '0;

endmodule

// File: tb/tb_state_dump.sv
// Scoreboard bench for state_dump: register file and data memory modelled as
// arrays, expected beats queued at start, monitor pops on each transfer.
module tb_state_dump;

  localparam int NR = 32;
  localparam int NM = 64;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          halt_req;
  logic          halt_ack;
  logic [4:0]    rf_raddr;
  logic [31:0]   rf_rdata;
  logic          mem_ren;
  logic [IW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_mem;
  logic [IW-1:0] out_idx;
  logic [31:0]   out_data;
  logic          busy;
  logic          done;

  state_dump #(.NUM_REGS(NR), .MEM_WORDS(NM), .IDX_W(IW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_mem(out_is_mem), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] rf_m  [NR];
  logic [31:0] mem_m [NM];

  assign rf_rdata = rf_m[rf_raddr];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem_m[mem_raddr];
  initial mem_rdata = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // 0: always ready, 1: alternate, 2: random, 3: held low
  int ready_mode = 0;
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  logic [40:0] exp_q[$];
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit seen_first = 0;
  int first_valid_cyc = 0;
  bit stall_prev = 0;
  logic [40:0] held;

  always @(negedge clk) begin
    logic [40:0] cur;
    logic [40:0] e;
    if (!n_rst) begin
      stall_prev = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        if (!seen_first) begin
          seen_first = 1;
          first_valid_cyc = cyc;
        end
        cur = {out_is_mem, out_idx, out_data};
        if (stall_prev) check("stall_hold", 64'(cur), 64'(held));
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 64'(cur), 64'h0);
          else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
          beats++;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          held = cur;
        end
      end else begin
        stall_prev = 0;
      end
    end
  end

  // The whole architectural dump in order: every register, then every memory word.
  task automatic queue_expected();
    for (int r = 0; r < NR; r++) exp_q.push_back({1'b0, IW'(r), rf_m[r]});
    for (int m = 0; m < NM; m++) exp_q.push_back({1'b1, IW'(m), mem_m[m]});
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({halt_req, busy, done, out_valid, mem_ren, rf_raddr, mem_raddr,
                out_is_mem, out_idx, out_data});
  endfunction

  task automatic run_dump(input bit chk_timing, input bit mid_start, input int ack_low);
    int b0, d0, start_cyc, a_cyc;
    bit pulsed, finished;
    queue_expected();
    b0 = beats;
    d0 = done_cnt;
    seen_first = 0;
    pulsed = 0;
    finished = 0;
    if (ack_low > 0) halt_ack = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
    a_cyc = start_cyc;
    if (ack_low > 0) begin
      repeat (ack_low) begin
        @(negedge clk);
        check("halt_hold", 64'({busy, halt_req, out_valid}), 64'(3'b110));
      end
      @(posedge clk); #1 halt_ack = 1'b1;
      a_cyc = cyc;
    end
    for (int i = 0; i < 4000 && !finished; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mid_start && !pulsed && out_valid && !out_is_mem && out_idx == IW'(5)) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (done_cnt != d0) finished = 1;
    end
    start = 1'b0;
    if (!finished) check("done_timeout", 64'(0), 64'(1));
    check("first_beat_latency", 64'(first_valid_cyc - a_cyc), 64'(2));
    // done is high 2 + 2*(NR-1) + 3*NM + 1 edges after start is sampled,
    // i.e. in the 258th cycle counting the start cycle itself.
    if (chk_timing)
      check("done_cycle", 64'(done_cyc - start_cyc), 64'(2 + 2 * (NR - 1) + 3 * NM + 1));
    check("beat_count", 64'(beats - b0), 64'(NR + NM));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    if (mid_start) check("mid_start_pulsed", 64'(pulsed), 64'(1));
    repeat (20) @(posedge clk);
    #1;
    check("single_done", 64'(done_cnt - d0), 64'(1));
    check("idle_after", 64'({busy, halt_req}), 64'(0));
  endtask

  initial begin
    bit found;
    n_rst = 1'b0;
    start = 1'b0;
    halt_ack = 1'b1;
    for (int r = 0; r < NR; r++) rf_m[r] = '0;
    for (int m = 0; m < NM; m++) mem_m[m] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 64'(0));
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Arithmetic program result: x1..x4 = 10, 5, 15, 5
    for (int r = 0; r < NR; r++) rf_m[r] = (r > 4) ? $urandom : 32'd0;
    rf_m[1] = 32'd10; rf_m[2] = 32'd5; rf_m[3] = 32'd15; rf_m[4] = 32'd5;
    for (int m = 0; m < NM; m++) mem_m[m] = $urandom;
    ready_mode = 0;
    run_dump(1, 0, 0);

    // Memory program result: mem[0] = 100, x2 = 100, x3 = 101
    for (int r = 0; r < NR; r++) rf_m[r] = '0;
    rf_m[2] = 32'd100; rf_m[3] = 32'd101;
    for (int m = 0; m < NM; m++) mem_m[m] = (m == 0) ? 32'd100 : $urandom;
    run_dump(1, 0, 0);

    // Alternating backpressure with index-tagged register values
    for (int r = 0; r < NR; r++) rf_m[r] = 32'(r) + 32'h100;
    ready_mode = 1;
    run_dump(0, 0, 0);

    // Random backpressure, random contents
    for (int r = 0; r < NR; r++) rf_m[r] = (r == 0) ? 32'd0 : $urandom;
    for (int m = 0; m < NM; m++) mem_m[m] = $urandom;
    ready_mode = 2;
    run_dump(0, 0, 0);

    // Halt acknowledge delayed 10 cycles
    ready_mode = 0;
    run_dump(0, 0, 10);

    // Start pulse while beat 5 is being sent
    run_dump(1, 1, 0);

    // Reset mid-stall in the memory phase, then a clean restart
    queue_expected();
    ready_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_is_mem && out_idx >= IW'(4)) found = 1;
    end
    check("reach_mem_phase", 64'(found), 64'(1));
    ready_mode = 3;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (out_valid && !out_ready) found = 1;
    end
    check("reach_stall", 64'(found), 64'(1));
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 64'(0));
    check("async_reset_halt_valid", 64'({halt_req, out_valid}), 64'(0));
    exp_q.delete();
    #3 n_rst = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    run_dump(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/state_dump.md
# state_dump

Debug readout engine for the single-cycle RISC-V core. On a start pulse it requests a core halt, reads every register-file entry and then the first `MEM_WORDS` words of data memory through dedicated read ports, and streams each value out as a tagged beat over a valid/ready interface. It is the hardware reader of the architectural state that the program loader and benches write, and it sits beside `top`, wired to the register-file and data-memory debug read ports.

## Interface
- `NUM_REGS`, 32: register-file entries dumped, indices 0..NUM_REGS-1, x0 included.
- `MEM_WORDS`, 64: data-memory words dumped, word addresses 0..MEM_WORDS-1.
- `IDX_W`, 8: width of the beat index; must satisfy 2^IDX_W ≥ max(NUM_REGS, MEM_WORDS).
- `clk`  in  1: clock. All sequential logic uses the rising edge.
- `n_rst`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle request to begin a dump.
- `halt_req`  out  1: tells the core to freeze.
- `halt_ack`  in  1: the core reports that it is frozen.
- `rf_raddr`  out  5: register-file debug read address. The register-file read is asynchronous.
- `rf_rdata`  in  32: register-file debug read data.
- `mem_ren`  out  1: data-memory debug read enable.
- `mem_raddr`  out  IDX_W: data-memory word address.
- `mem_rdata`  in  32: data-memory read data, valid one cycle after `mem_ren`.
- `out_valid`  out  1: a beat is present.
- `out_ready`  in  1: the sink accepts the beat.
- `out_is_mem`  out  1: 0 for a register beat, 1 for a memory beat.
- `out_idx`  out  IDX_W: register number or word address of the beat.
- `out_data`  out  32: beat payload.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the dump completes.

## Operation
- States:
  - IDLE: waits for `start`, then goes to HALT and clears the phase bit and the index to 0.
  - HALT: `halt_req`=1. Goes to RD when `halt_ack`=1.
  - RD: drives the read address for the current index.
    - Register phase: captures `rf_rdata` at the end of the cycle, then goes to SEND.
    - Memory phase: asserts `mem_ren`, then goes to WAIT.
  - WAIT: memory phase only. Captures `mem_rdata`, then goes to SEND.
  - SEND: `out_valid`=1. On `out_ready`:
    - if this is not the last beat of the phase, increment the index and go to RD;
    - if this is the last register beat, set the phase to memory, clear the index and go to RD;
    - if this is the last memory beat, go to DONE.
  - DONE: `done`=1 for one cycle, then goes to IDLE.
- `halt_req` is high from HALT through DONE and low in IDLE.
- `out_is_mem`, `out_idx` and `out_data` are registered. They stay stable for the whole time `out_valid` is high.
- `start` is ignored outside IDLE.
- The index counter never wraps. The terminal compare is exact: `NUM_REGS`-1 for the register phase and `MEM_WORDS`-1 for the memory phase.
- Total beats per dump: `NUM_REGS` + `MEM_WORDS`. Beat order is strictly ascending: all registers first, then all memory words.
- Read outputs:
  - `rf_raddr` equals the index in the register phase and 0 otherwise.
  - `mem_raddr` equals the index in the memory phase and 0 otherwise.
  - `mem_ren` is high only in RD during the memory phase.

## Timing
- Reset values: state IDLE, index 0, phase 0, and every output 0 (`halt_req`, `busy`, `done`, `out_valid`, `mem_ren`, `rf_raddr`, `mem_raddr`, `out_is_mem`, `out_idx`, `out_data`).
- Reset is asynchronous. Asserting `n_rst` mid-dump clears all state immediately. `halt_req` and `out_valid` drop without waiting for a clock edge, and any partially sent beat is dropped.
- Start latency, with `halt_ack` tied high:
  - `start` sampled at edge 0 puts the block in HALT.
  - Edge 1 enters RD.
  - Edge 2 enters SEND, so the first beat is valid from cycle 2.
- Throughput with `out_ready` held high:
  - a register beat every 2 cycles;
  - a memory beat every 3 cycles.
- Full dump time at defaults: 2 + 64 + 192 = 258 cycles to DONE.
- Backpressure: `out_ready` low holds SEND indefinitely with the beat unchanged.
- A beat transfers on any edge where `out_valid` and `out_ready` are both high.
- `halt_ack` low holds HALT indefinitely.
- If `halt_ack` drops after HALT, the dump continues; no re-check is made.

## Structure
- The package `state_dump_pkg` holds:
  - the state enum `dump_state_t` (IDLE, HALT, RD, WAIT, SEND, DONE);
  - the phase enum (PH_RF, PH_MEM);
  - the register-file address width constant, 5.
- A single module. No sub-module is warranted; the output register sits inline with the FSM.

## Test plan
- Arithmetic program, then dump with `out_ready`=1:
  - register beats 1..4 carry 10, 5, 15, 5;
  - beat 0 carries 0;
  - exactly 96 beats are sent, then `done` pulses at cycle 258.
- Memory program, then dump:
  - memory beat with `out_idx`=0 and `out_is_mem`=1 carries 100;
  - register beats 2 and 3 carry 100 and 101.
- Backpressure: `out_ready` toggled 1010…, register values preset to the index plus 0x100:
  - every beat is delivered exactly once, in order, with unchanged data while stalled.
- `halt_ack` held low for 10 cycles:
  - `busy`=1 and `halt_req`=1 throughout;
  - no `out_valid`;
  - the first beat appears 2 cycles after `halt_ack` rises.
- `start` pulsed during SEND of beat 5:
  - ignored; the dump finishes with exactly 96 beats and one `done`.
- `n_rst` asserted during the memory phase, mid-stall:
  - all outputs read 0 immediately;
  - a following `start` restarts the dump from register beat 0.
